// File: rtl/irq_sched_27.sv
// Priority-interrupt front end: latches request edges from three 9-channel buses,
// picks a fixed-priority winner and runs the host ack/EOI handshake.
module irq_sched_27 #(
  parameter int unsigned NCH   = 9,
  parameter int unsigned VEC_W = 5
) (
  input  logic               CK,
  input  logic               RN,
  input  logic [NCH-1:0]     req_a,
  input  logic [NCH-1:0]     req_b,
  input  logic [NCH-1:0]     req_c,
  input  logic [NCH-1:0]     en_i,
  input  logic               ack_i,
  input  logic               eoi_i,
  output logic               irq_o,
  output logic [VEC_W-1:0]   vec_o,
  output logic               busy_o,
  output logic [3*NCH-1:0]   pend_o
);

  localparam int unsigned NB = 3 * NCH;

  typedef enum logic [1:0] {StIdle, StPend, StService} state_e;

  state_e            state_q, state_d;
  logic [NB-1:0]     req_q;
  logic [NB-1:0]     pend_q, pend_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic              irq_q, irq_d;
  logic              busy_q, busy_d;

  logic [NB-1:0]     req_all;
  logic [NB-1:0]     set_bits;
  logic [NB-1:0]     clr_bits;
  logic [NB-1:0]     elig;
  logic [VEC_W-1:0]  winner;

  assign req_all  = {req_c, req_b, req_a};
  assign set_bits = req_all & ~req_q;
  assign elig     = pend_q & {en_i, en_i, en_i};

  // Bit index equals vector, so the lowest set bit is the highest-priority request.
  always_comb begin
    winner = '0;
    for (int i = int'(NB) - 1; i >= 0; i--) begin
      if (elig[i]) winner = VEC_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    irq_d    = irq_q;
    busy_d   = busy_q;
    clr_bits = '0;
    unique case (state_q)
      StIdle: begin
        if (elig != '0) begin
          vec_d   = winner;
          irq_d   = 1'b1;
          state_d = StPend;
        end
      end
      StPend: begin
        if (ack_i) begin
          clr_bits[vec_q] = 1'b1;
          irq_d           = 1'b0;
          busy_d          = 1'b1;
          state_d         = StService;
        end
      end
      StService: begin
        if (eoi_i) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A fresh edge on the bit being acknowledged must survive the clear.
    pend_d = (pend_q & ~clr_bits) | set_bits;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      req_q   <= '0;
      pend_q  <= '0;
      vec_q   <= '0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_all;
      pend_q  <= pend_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
    end
  end

  assign irq_o  = irq_q;
  assign vec_o  = vec_q;
  assign busy_o = busy_q;
  assign pend_o = pend_q;

endmodule
